plc_input_image: RTL and testbench



---
 rtl/plc_io_pkg.sv | 8 +
 rtl/plc_input_image_if.sv | 12 +
 rtl/plc_debounce_bit.sv | 38 +++
 rtl/plc_input_image.sv | 69 ++++++
 tb/tb_plc_input_image.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/plc_io_pkg.sv
// plc_io_pkg: shared constants and snapshot state type for the PLC input image
package plc_io_pkg;
  localparam int TICK_HZ = 1000;
  localparam int N_IN_DEF = 6;
  localparam int DEB_TICKS_DEF = 5;
  localparam int WDOG_TICKS_DEF = 100;
  typedef enum logic [1:0] {FIRST, RUN, IDLE} snap_state_e;
endpackage

// File: rtl/plc_input_image_if.sv
// plc_input_image_if: snapshot bus between the scan sequencer and the input image reader
interface plc_input_image_if #(parameter int N_IN = plc_io_pkg::N_IN_DEF);
  logic snap_req;
  logic img_valid;
  logic scan_fault;
  logic [N_IN-1:0] img;
  logic [N_IN-1:0] img_rise;
  logic [N_IN-1:0] img_fall;
  logic [N_IN-1:0] deb;
  modport master (output snap_req, input img, img_rise, img_fall, img_valid, deb, scan_fault);
  modport slave (input snap_req, output img, img_rise, img_fall, img_valid, deb, scan_fault);
endinterface

// File: rtl/plc_debounce_bit.sv
// plc_debounce_bit: two-flop synchronizer, optional inversion and tick-based debounce for one input
import plc_io_pkg::*;
module plc_debounce_bit #(
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic deb
);
  localparam int CW = DEB_TICKS > 0 ? $clog2(DEB_TICKS + 1) : 1;
  logic [1:0] sync_q, sync_d;
  logic deb_q, deb_d, s, last;
  logic [CW-1:0] cnt_q, cnt_d;
  // next state: shift synchronizer, count ticks while the level disagrees, accept on the final tick
  always_comb begin
    sync_d = {sync_q[0], raw};
    s = sync_q[1] ^ ACTIVE_LOW;
    last = int'(cnt_q) + 1 >= DEB_TICKS;
    cnt_d = (s == deb_q) ? '0 : !tick ? cnt_q : last ? '0 : cnt_q + 1'b1;
    deb_d = (s != deb_q && tick && last) ? s : deb_q;
  end
  // state register; synchronizer resets to the idle raw level so s starts deasserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {2{ACTIVE_LOW}};
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  assign deb = (DEB_TICKS == 0) ? s : deb_q;
endmodule

// File: rtl/plc_input_image.sv
// plc_input_image: debounced input image with snapshot edge flags and scan-rate watchdog
import plc_io_pkg::*;
module plc_input_image #(
  parameter int N_IN = N_IN_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int WDOG_TICKS = WDOG_TICKS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_IN-1:0] raw_in,
  plc_input_image_if.slave bus
);
  localparam int WW = $clog2(WDOG_TICKS + 1);
  logic [N_IN-1:0] deb;
  logic [N_IN-1:0] img_q, img_d, rise_q, rise_d, fall_q, fall_d;
  logic valid_q, valid_d, fault_q, fault_d, snap, wdog_sat, wdog_hit;
  logic [WW-1:0] wcnt_q, wcnt_d;
  snap_state_e state_q, state_d;
  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    plc_debounce_bit #(.DEB_TICKS(DEB_TICKS), .ACTIVE_LOW(ACTIVE_LOW)) u_deb (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .raw(raw_in[g]),
      .deb(deb[g])
    );
  end
  // snapshot FSM and watchdog next state; a snap on the terminal tick wins over the fault
  always_comb begin
    snap = bus.snap_req;
    wdog_sat = wcnt_q == WW'(WDOG_TICKS);
    wdog_hit = state_q != FIRST && !snap && tick && !wdog_sat && int'(wcnt_q) + 1 >= WDOG_TICKS;
    wcnt_d = (state_q == FIRST || snap) ? '0 : (tick && !wdog_sat) ? wcnt_q + 1'b1 : wcnt_q;
    fault_d = fault_q | wdog_hit;
    state_d = (state_q == FIRST) ? (snap ? RUN : FIRST) : (state_q == RUN && wdog_hit) ? IDLE : state_q;
    img_d = snap ? deb : img_q;
    rise_d = !snap ? rise_q : (state_q == FIRST) ? '0 : deb & ~img_q;
    fall_d = !snap ? fall_q : (state_q == FIRST) ? '0 : ~deb & img_q;
    valid_d = snap;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FIRST;
      img_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      img_q <= img_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign bus.img = img_q;
  assign bus.img_rise = rise_q;
  assign bus.img_fall = fall_q;
  assign bus.img_valid = valid_q;
  assign bus.scan_fault = fault_q;
  assign bus.deb = deb;
endmodule

// File: tb/tb_plc_input_image.sv
// tb_plc_input_image: randomized and directed checks against a window-based reference model
module tb_plc_input_image;
  localparam int N = 6;
  localparam int DT = 5;
  localparam int WD = 100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic [N-1:0] raw_in = '1;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_deb, m_img, m_rise, m_fall;
  logic [N-1:0] hist[$];
  bit m_first, m_fault;
  int m_wcnt;
  plc_input_image_if #(.N_IN(N)) bus ();
  plc_input_image #(.N_IN(N), .DEB_TICKS(DT), .ACTIVE_LOW(1'b1), .WDOG_TICKS(WD)) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .raw_in(raw_in),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_deb = '0; m_img = '0; m_rise = '0; m_fall = '0;
    hist.delete();
    m_first = 1; m_fault = 0; m_wcnt = 0;
  endtask
  task automatic tk();
    bit flip;
    repeat (5) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    hist.push_back(~raw_in);
    for (int b = 0; b < N; b++) begin
      flip = hist.size() >= DT;
      for (int k = 0; k < DT && flip; k++)
        if (hist[hist.size() - 1 - k][b] == m_deb[b]) flip = 0;
      if (flip) m_deb[b] = ~m_deb[b];
    end
    if (!m_first) begin
      m_wcnt++;
      if (m_wcnt >= WD) m_fault = 1;
    end
    check("deb", bus.deb, m_deb);
    check("fault_tick", bus.scan_fault, m_fault);
  endtask
  task automatic snap(input int n);
    bus.snap_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (m_first) begin
        m_rise = '0; m_fall = '0; m_first = 0;
      end else begin
        m_rise = m_deb & ~m_img;
        m_fall = ~m_deb & m_img;
      end
      m_img = m_deb;
      m_wcnt = 0;
      step();
      check("valid", bus.img_valid, 1);
      check("img", bus.img, m_img);
      check("rise", bus.img_rise, m_rise);
      check("fall", bus.img_fall, m_fall);
      check("fault_snap", bus.scan_fault, m_fault);
    end
    bus.snap_req = 1'b0;
    step();
    check("valid_low", bus.img_valid, 0);
    check("rise_hold", bus.img_rise, m_rise);
  endtask
  task automatic check_cleared();
    check("rst_img", bus.img, 0);
    check("rst_rise", bus.img_rise, 0);
    check("rst_fall", bus.img_fall, 0);
    check("rst_valid", bus.img_valid, 0);
    check("rst_deb", bus.deb, 0);
    check("rst_fault", bus.scan_fault, 0);
  endtask
  initial begin
    bus.snap_req = 1'b0;
    model_reset();
    repeat (3) step();
    check_cleared();
    rst = 1'b1;
    raw_in = 6'b111110;
    repeat (6) tk();
    check("sw0_deb", bus.deb, 6'b000001);
    snap(1);
    check("first_img", bus.img, 6'b000001);
    check("first_rise", bus.img_rise, 0);
    for (int it = 0; it < 60; it++) begin
      raw_in = raw_in ^ N'($urandom & $urandom);
      repeat ($urandom_range(1, 7)) tk();
      if ($urandom_range(0, 1) == 1 || m_wcnt > 80) snap($urandom_range(1, 2));
    end
    raw_in = '1;
    repeat (6) tk();
    snap(1);
    raw_in[2] = 1'b0;
    repeat (3) tk();
    raw_in[2] = 1'b1;
    repeat (6) tk();
    check("glitch_deb", bus.deb, 0);
    snap(1);
    check("glitch_rise", bus.img_rise, 0);
    raw_in[2] = 1'b0;
    repeat (5) tk();
    snap(1);
    check("b2_rise", bus.img_rise, 6'b000100);
    raw_in[2] = 1'b1;
    repeat (5) tk();
    snap(1);
    check("b2_fall", bus.img_fall, 6'b000100);
    check("b2_fall_rise", bus.img_rise, 0);
    raw_in[1] = 1'b0;
    repeat (5) tk();
    snap(4);
    repeat (99) tk();
    check("wdog_99", bus.scan_fault, 0);
    tk();
    check("wdog_100", bus.scan_fault, 1);
    snap(1);
    check("wdog_sticky", bus.scan_fault, 1);
    raw_in = '1;
    repeat (6) tk();
    raw_in[0] = 1'b0;
    repeat (3) tk();
    #2 rst = 1'b0;
    model_reset();
    #1 check_cleared();
    step();
    rst = 1'b1;
    repeat (4) tk();
    check("post_rst_4", bus.deb, 0);
    tk();
    check("post_rst_5", bus.deb, 6'b000001);
    snap(1);
    check("post_rst_rise", bus.img_rise, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
